axi_stream_strip_header: RTL

//  Removes a per-packet header of 1..DATA_BYTE_WD bytes from the front of an AXI-Stream packet.

---
 rtl/axi_stream_strip_header.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//   Removes an S-byte header (S = 1..DATA_BYTE_WD) from the front of each
//   AXI-Stream packet. The remaining payload is realigned to start at the MSB
//   byte lane, and keep/last are regenerated for the shortened packet. The
//   strip length for each packet arrives on its own valid/ready sideband.
//   Only one packet is in flight at a time.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   valid_in/data_in/keep_in/last_in upstream beat (byte 0 = data_in MSB byte)
//   ready_in                         upstream accept
//   valid_out/data_out/keep_out/last_out  realigned downstream beat
//   ready_out                        downstream accept
//   valid_strip/byte_strip_cnt       strip length S = byte_strip_cnt + 1
//   ready_strip                      strip length accept (only in IDLE)
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip
);
    // One extra bit so byte counts can represent the full range 0..DATA_BYTE_WD.
    localparam int                CNT_WD = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0] LANES  = CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_BODY,
        ST_FLUSH
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_WD-1:0]  strip_reg, strip_next;   // S, header bytes to drop
    logic [CNT_WD-1:0]  tail_reg,  tail_next;    // bytes left for the flush beat
    logic [DATA_WD-1:0] hold_reg,  hold_next;    // leftover bytes, MSB-aligned

    logic [CNT_WD-1:0]       in_bytes;
    logic [CNT_WD-1:0]       extra_bytes;
    logic                    has_extra;
    logic [CNT_WD+2:0]       head_shift;
    logic [CNT_WD+2:0]       tail_shift;
    logic [DATA_WD-1:0]      head_data;
    logic [DATA_WD-1:0]      tail_data;
    logic [DATA_WD-1:0]      head_masked;
    logic [DATA_BYTE_WD-1:0] extra_keep;
    logic [DATA_WD-1:0]      extra_mask;
    logic [DATA_WD-1:0]      lane_mask;

    logic                    ready_in_c;
    logic                    ready_strip_c;
    logic                    valid_c;
    logic                    last_c;
    logic [DATA_BYTE_WD-1:0] keep_c;
    logic [DATA_WD-1:0]      raw_data;

    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [CNT_WD-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    // Number of valid bytes in the incoming beat (keep is contiguous).
    always_comb begin
        in_bytes = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            in_bytes = in_bytes + CNT_WD'(keep_in[i]);
        end
    end

    assign has_extra   = in_bytes > strip_reg;
    assign extra_bytes = in_bytes - strip_reg;
    assign extra_keep  = msb_ones(extra_bytes);

    // head_data: bytes S..W-1 of the beat moved up to the MSB lanes (becomes hold).
    // tail_data: bytes 0..S-1 of the beat moved down to the LSB lanes, filling
    // the gap below the W-S held bytes. S=W makes hold empty and tail the whole beat.
    assign head_shift  = {strip_reg, 3'b000};
    assign tail_shift  = {LANES - strip_reg, 3'b000};
    assign head_data   = data_in << head_shift;
    assign tail_data   = data_in >> tail_shift;
    assign head_masked = head_data & extra_mask;

    for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8]  = {8{keep_c[gi]}};
        assign extra_mask[gi*8 +: 8] = {8{extra_keep[gi]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            strip_reg <= '0;
            tail_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            strip_reg <= strip_next;
            tail_reg  <= tail_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        strip_next    = strip_reg;
        tail_next     = tail_reg;
        hold_next     = hold_reg;
        ready_in_c    = 1'b0;
        ready_strip_c = 1'b0;
        valid_c       = 1'b0;
        last_c        = 1'b0;
        keep_c        = '0;
        raw_data      = '0;

        case (state_reg)
            ST_IDLE: begin
                ready_strip_c = 1'b1;
                if (valid_strip) begin
                    strip_next = CNT_WD'(byte_strip_cnt) + CNT_WD'(1);
                    state_next = ST_FIRST;
                end
            end

            ST_FIRST: begin
                // The first beat only fills hold; nothing leaves yet.
                ready_in_c = 1'b1;
                if (valid_in) begin
                    if (!last_in) begin
                        hold_next  = head_data;
                        state_next = ST_BODY;
                    end else if (has_extra) begin
                        hold_next  = head_masked;
                        tail_next  = extra_bytes;
                        state_next = ST_FLUSH;
                    end else begin
                        // Whole packet was header: drop it silently.
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_BODY: begin
                valid_c    = valid_in;
                ready_in_c = ready_out;
                raw_data   = hold_reg | tail_data;
                if (last_in && !has_extra) begin
                    keep_c = msb_ones(LANES - strip_reg + in_bytes);
                    last_c = 1'b1;
                end else begin
                    keep_c = '1;
                end
                if (valid_in && ready_out) begin
                    if (!last_in) begin
                        hold_next = head_data;
                    end else if (has_extra) begin
                        hold_next  = head_masked;
                        tail_next  = extra_bytes;
                        state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                valid_c  = 1'b1;
                raw_data = hold_reg;
                keep_c   = msb_ones(tail_reg);
                last_c   = 1'b1;
                if (ready_out) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet for the whole reset cycle, even though the
    // state register only clears at the edge.
    assign ready_in    = !rst && ready_in_c;
    assign ready_strip = !rst && ready_strip_c;
    assign valid_out   = !rst && valid_c;
    assign last_out    = !rst && last_c;
    assign keep_out    = rst ? '0 : keep_c;
    assign data_out    = rst ? '0 : (raw_data & lane_mask);

endmodule
